// File: rtl/mem_stage_if.sv
// Execute-to-memory stage handshake and payload bundle.
// Carries es_ld_type only when MEM_SUBWORD_LOAD_EN is defined.
interface mem_stage_if #(
   parameter int RF_ADDR_W = 5,
   parameter int DATA_W    = 32
);
   logic                 es_to_ms_valid;
   logic                 ms_allowin;
   logic [DATA_W-1:0]    es_pc;
   logic                 es_rf_we;
   logic [RF_ADDR_W-1:0] es_rf_waddr;
   logic [DATA_W-1:0]    es_alu_result;
   logic                 es_res_from_mem;
`ifdef MEM_SUBWORD_LOAD_EN
   logic [2:0]           es_ld_type;
`endif

   modport master (
      output es_to_ms_valid,
      output es_pc,
      output es_rf_we,
      output es_rf_waddr,
      output es_alu_result,
      output es_res_from_mem,
`ifdef MEM_SUBWORD_LOAD_EN
      output es_ld_type,
`endif
      input  ms_allowin
   );

   modport slave (
      input  es_to_ms_valid,
      input  es_pc,
      input  es_rf_we,
      input  es_rf_waddr,
      input  es_alu_result,
      input  es_res_from_mem,
`ifdef MEM_SUBWORD_LOAD_EN
      input  es_ld_type,
`endif
      output ms_allowin
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: captures SRAM read data, selects writeback data.
// Optional sub-word loads enabled by defining MEM_SUBWORD_LOAD_EN.
module mem_stage #(
   parameter int RF_ADDR_W = 5,
   parameter int DATA_W    = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 ws_allowin,
   mem_stage_if.slave           es,
   input  logic [DATA_W-1:0]    data_sram_rdata,
   output logic                 ms_to_ws_valid,
   output logic [DATA_W-1:0]    ms_pc,
   output logic                 ms_rf_we,
   output logic [RF_ADDR_W-1:0] ms_rf_waddr,
   output logic [DATA_W-1:0]    ms_rf_wdata,
   output logic                 ms_res_from_mem
);

   typedef struct packed {
      logic [DATA_W-1:0]    pc;
      logic                 rf_we;
      logic [RF_ADDR_W-1:0] rf_waddr;
      logic [DATA_W-1:0]    alu_result;
      logic                 res_from_mem;
`ifdef MEM_SUBWORD_LOAD_EN
      logic [2:0]           ld_type;
`endif
   } es_ms_t;

   es_ms_t            ms_q;
   es_ms_t            es_d;
   logic              ms_valid;
   logic              ms_first;
   logic              ms_ready_go;
   logic              ms_allowin;
   logic              accept;
   logic [DATA_W-1:0] rdata_hold;
   logic [DATA_W-1:0] mem_word;
   logic [DATA_W-1:0] load_data;

   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign es.ms_allowin  = ms_allowin;
   assign accept         = es.es_to_ms_valid && ms_allowin;
   assign ms_to_ws_valid = ms_valid && ms_ready_go;

   always_comb begin
      es_d              = '0;
      es_d.pc           = es.es_pc;
      es_d.rf_we        = es.es_rf_we;
      es_d.rf_waddr     = es.es_rf_waddr;
      es_d.alu_result   = es.es_alu_result;
      es_d.res_from_mem = es.es_res_from_mem;
`ifdef MEM_SUBWORD_LOAD_EN
      es_d.ld_type      = es.es_ld_type;
`endif
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ms_valid <= 1'b0;
      end else if (ms_allowin) begin
         ms_valid <= es.es_to_ms_valid;
      end
   end

   // SRAM data is only valid in the first cycle after accept
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ms_first <= 1'b0;
      end else begin
         ms_first <= accept;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ms_q <= '0;
      end else if (accept) begin
         ms_q <= es_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rdata_hold <= '0;
      end else if (ms_first) begin
         rdata_hold <= data_sram_rdata;
      end
   end

   assign mem_word = ms_first ? data_sram_rdata : rdata_hold;

`ifdef MEM_SUBWORD_LOAD_EN
   logic [1:0]  addr_lo;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign addr_lo = ms_q.alu_result[1:0];
   assign ld_half = addr_lo[1] ? mem_word[31:16]
                               : mem_word[15:0];

   always_comb begin
      ld_byte = mem_word[7:0];
      unique case (addr_lo)
         2'd0: ld_byte = mem_word[7:0];
         2'd1: ld_byte = mem_word[15:8];
         2'd2: ld_byte = mem_word[23:16];
         2'd3: ld_byte = mem_word[31:24];
      endcase
   end

   always_comb begin
      load_data = mem_word;
      unique case (1'b1)
         (ms_q.ld_type == 3'd1):
            load_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
         (ms_q.ld_type == 3'd2):
            load_data = {{(DATA_W-8){1'b0}}, ld_byte};
         (ms_q.ld_type == 3'd3):
            load_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
         (ms_q.ld_type == 3'd4):
            load_data = {{(DATA_W-16){1'b0}}, ld_half};
         default:
            load_data = mem_word;
      endcase
   end
`else
   assign load_data = mem_word;
`endif

   assign ms_pc           = ms_q.pc;
   assign ms_rf_waddr     = ms_q.rf_waddr;
   assign ms_rf_we        = ms_valid && ms_q.rf_we;
   assign ms_res_from_mem = ms_valid && ms_q.res_from_mem;
   assign ms_rf_wdata     = ms_q.res_from_mem ? load_data
                                              : ms_q.alu_result;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Define MEM_SUBWORD_LOAD_EN to cover sub-word loads as well.
module tb_mem_stage;

   logic        clk;
   logic        resetn;
   logic        ws_allowin;
   logic [31:0] data_sram_rdata;
   logic        ms_to_ws_valid;
   logic [31:0] ms_pc;
   logic        ms_rf_we;
   logic [4:0]  ms_rf_waddr;
   logic [31:0] ms_rf_wdata;
   logic        ms_res_from_mem;

   int errs;
   int checks;

   mem_stage_if #(.RF_ADDR_W(5), .DATA_W(32)) es_if ();

   mem_stage #(.RF_ADDR_W(5), .DATA_W(32)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .ws_allowin      (ws_allowin),
      .es              (es_if),
      .data_sram_rdata (data_sram_rdata),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ms_pc           (ms_pc),
      .ms_rf_we        (ms_rf_we),
      .ms_rf_waddr     (ms_rf_waddr),
      .ms_rf_wdata     (ms_rf_wdata),
      .ms_res_from_mem (ms_res_from_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic        v,
                        input logic [31:0] pc,
                        input logic        we,
                        input logic [4:0]  wa,
                        input logic [31:0] res,
                        input logic        ld,
                        input logic [2:0]  lt);
      es_if.es_to_ms_valid  = v;
      es_if.es_pc           = pc;
      es_if.es_rf_we        = we;
      es_if.es_rf_waddr     = wa;
      es_if.es_alu_result   = res;
      es_if.es_res_from_mem = ld;
`ifdef MEM_SUBWORD_LOAD_EN
      es_if.es_ld_type      = lt;
`else
      if (lt != 3'd0) $display("note: ld_type ignored");
`endif
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 3'd0);
   endtask

   initial begin
      errs            = 0;
      checks          = 0;
      resetn          = 1'b0;
      ws_allowin      = 1'b1;
      data_sram_rdata = 32'h0;
      idle();

      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid",   {31'd0, ms_to_ws_valid},  32'd0);
      chk("rst_allowin", {31'd0, es_if.ms_allowin}, 32'd1);
      chk("rst_we",      {31'd0, ms_rf_we},        32'd0);
      chk("rst_wdata",   ms_rf_wdata,              32'd0);
      chk("rst_pc",      ms_pc,                    32'd0);
      chk("rst_waddr",   {27'd0, ms_rf_waddr},     32'd0);
      chk("rst_ld",      {31'd0, ms_res_from_mem}, 32'd0);

      // single ALU op then bubble
      @(negedge clk);
      resetn = 1'b1;
      drive(1'b1, 32'h1c000004, 1'b1, 5'd5, 32'h12345678, 1'b0, 3'd0);
      @(negedge clk);
      idle();
      #1;
      chk("alu_valid", {31'd0, ms_to_ws_valid}, 32'd1);
      chk("alu_wdata", ms_rf_wdata,             32'h12345678);
      chk("alu_we",    {31'd0, ms_rf_we},       32'd1);
      chk("alu_waddr", {27'd0, ms_rf_waddr},    32'd5);
      chk("alu_pc",    ms_pc,                   32'h1c000004);
      @(negedge clk);
      #1;
      chk("bub_valid", {31'd0, ms_to_ws_valid}, 32'd0);
      chk("bub_we",    {31'd0, ms_rf_we},       32'd0);

      // load stalled by writeback; SRAM data goes away after cycle 1
      @(negedge clk);
      ws_allowin = 1'b0;
      drive(1'b1, 32'h1c000008, 1'b1, 5'd7, 32'h00000100, 1'b1, 3'd0);
      @(negedge clk);
      idle();
      data_sram_rdata = 32'hDEADBEEF;
      #1;
      chk("ld1_valid",   {31'd0, ms_to_ws_valid},   32'd1);
      chk("ld1_wdata",   ms_rf_wdata,               32'hDEADBEEF);
      chk("ld1_allowin", {31'd0, es_if.ms_allowin}, 32'd0);
      chk("ld1_isload",  {31'd0, ms_res_from_mem},  32'd1);
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         data_sram_rdata = 32'h0;
         #1;
         chk($sformatf("ld%0d_valid", c),
             {31'd0, ms_to_ws_valid}, 32'd1);
         chk($sformatf("ld%0d_wdata", c),
             ms_rf_wdata, 32'hDEADBEEF);
         chk($sformatf("ld%0d_allowin", c),
             {31'd0, es_if.ms_allowin}, 32'd0);
         chk($sformatf("ld%0d_waddr", c),
             {27'd0, ms_rf_waddr}, 32'd7);
      end

      // reset while the stalled load is held
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      #1;
      chk("rstld_valid", {31'd0, ms_to_ws_valid},  32'd0);
      chk("rstld_isld",  {31'd0, ms_res_from_mem}, 32'd0);
      chk("rstld_we",    {31'd0, ms_rf_we},        32'd0);

      // four back-to-back ALU ops
      @(negedge clk);
      resetn     = 1'b1;
      ws_allowin = 1'b1;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         if (i < 4)
            drive(1'b1, 32'h1c000100 + 32'(4 * i), 1'b1,
                  5'(i + 1), 32'hA0000000 + 32'(i), 1'b0, 3'd0);
         else
            idle();
         #1;
         if (i > 0) begin
            chk($sformatf("b2b%0d_valid", i),
                {31'd0, ms_to_ws_valid}, 32'd1);
            chk($sformatf("b2b%0d_pc", i),
                ms_pc, 32'h1c000100 + 32'(4 * (i - 1)));
            chk($sformatf("b2b%0d_wdata", i),
                ms_rf_wdata, 32'hA0000000 + 32'(i - 1));
            chk($sformatf("b2b%0d_waddr", i),
                {27'd0, ms_rf_waddr}, 32'(i));
            chk($sformatf("b2b%0d_allowin", i),
                {31'd0, es_if.ms_allowin}, 32'd1);
         end
      end
      @(negedge clk);
      #1;
      chk("b2b_end_valid", {31'd0, ms_to_ws_valid}, 32'd0);

`ifdef MEM_SUBWORD_LOAD_EN
      // lb at offset 2, stalled one cycle to cover the held path
      @(negedge clk);
      ws_allowin = 1'b0;
      drive(1'b1, 32'h1c000200, 1'b1, 5'd9, 32'h00000102, 1'b1, 3'd1);
      @(negedge clk);
      idle();
      data_sram_rdata = 32'h80FF7F01;
      #1;
      chk("lb_live", ms_rf_wdata, 32'hFFFFFFFF);
      @(negedge clk);
      data_sram_rdata = 32'h0;
      #1;
      chk("lb_hold", ms_rf_wdata, 32'hFFFFFFFF);
      ws_allowin = 1'b1;

      // lh upper half, then lhu lower half back to back
      @(negedge clk);
      drive(1'b1, 32'h1c000204, 1'b1, 5'd10, 32'h00000102, 1'b1, 3'd3);
      @(negedge clk);
      drive(1'b1, 32'h1c000208, 1'b1, 5'd11, 32'h00000100, 1'b1, 3'd4);
      data_sram_rdata = 32'h80FF7F01;
      #1;
      chk("lh_live", ms_rf_wdata, 32'hFFFF80FF);
      @(negedge clk);
      idle();
      data_sram_rdata = 32'h80FF7F01;
      #1;
      chk("lhu_live", ms_rf_wdata, 32'h00007F01);

      // lbu at offset 1 and undefined encoding as word
      @(negedge clk);
      drive(1'b1, 32'h1c00020c, 1'b1, 5'd12, 32'h00000101, 1'b1, 3'd2);
      @(negedge clk);
      drive(1'b1, 32'h1c000210, 1'b1, 5'd13, 32'h00000103, 1'b1, 3'd7);
      data_sram_rdata = 32'h80FF7F01;
      #1;
      chk("lbu_live", ms_rf_wdata, 32'h0000007F);
      @(negedge clk);
      idle();
      data_sram_rdata = 32'h80FF7F01;
      #1;
      chk("ldundef_live", ms_rf_wdata, 32'h80FF7F01);
      @(negedge clk);
      data_sram_rdata = 32'h0;
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage; the receiving end of the execute-stage to memory-stage valid/allowin handshake.
- Accepts one instruction per handshake from the execute stage and captures the synchronous data-SRAM read data, which arrives one cycle after the request.
- Selects the register-file write data and forwards it to the writeback stage.
- Exports its destination register and load status to the decode stage for forwarding and load-use interlock.

Parameters:
- RF_ADDR_W, 5, width of register-file address fields.
- DATA_W, 32, width of PC, ALU result, SRAM read data and writeback data.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- ws_allowin  in  1  writeback stage can accept this cycle.
- ms_allowin  out  1  this stage can accept from execute this cycle.
- es_to_ms_valid  in  1  execute stage presents a valid instruction.
- es_pc  in  DATA_W  PC of the presented instruction.
- es_rf_we  in  1  instruction writes the register file.
- es_rf_waddr  in  RF_ADDR_W  destination register.
- es_alu_result  in  DATA_W  ALU result, which is also the memory address.
- es_res_from_mem  in  1  instruction is a load.
- data_sram_rdata  in  DATA_W  SRAM read data, valid exactly one cycle after the request cycle.
- ms_to_ws_valid  out  1  valid instruction offered to writeback.
- ms_pc  out  DATA_W  PC of the held instruction.
- ms_rf_we  out  1  write enable, gated by ms_valid.
- ms_rf_waddr  out  RF_ADDR_W  destination register.
- ms_rf_wdata  out  DATA_W  selected writeback data.
- ms_res_from_mem  out  1  held instruction is a load, gated by ms_valid (decode uses it for load-use interlock).

Behaviour:
- Reset, when resetn is low at a clk edge: ms_valid, ms_first, ms_rf_we, ms_res_from_mem, ms_rf_waddr, ms_pc, held alu_result and rdata_hold all go to 0. All outputs therefore read 0 after reset.
- Stage signals:
  - ms_ready_go is always 1; there is no internal stall.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_to_ws_valid = ms_valid.
- Handshake (accept) happens when es_to_ms_valid && ms_allowin. On that edge:
  - capture pc, rf_we, rf_waddr, alu_result and res_from_mem;
  - set ms_valid=1 and ms_first=1.
- If ms_allowin is high and es_to_ms_valid is low: ms_valid goes to 0 (bubble) and payload registers keep their values.
- If ms_allowin is low: everything holds, including ms_valid and the payload.
- Read-data capture:
  - In the first cycle after accept (ms_first=1), data_sram_rdata is valid. At that edge it is latched into rdata_hold.
  - ms_first is cleared on every edge that is not an accept.
  - The upstream stage may issue a new SRAM request while this stage stalls, so data_sram_rdata must not be used after the first cycle.
- Write-data select:
  - If res_from_mem: ms_rf_wdata = ms_first ? data_sram_rdata : rdata_hold.
  - Otherwise: ms_rf_wdata = held alu_result.
  - The select is combinational, so wdata is correct in the same cycle ms_to_ws_valid rises.
- Back-to-back accepts, where accept occurs while ms_valid=1 and ws_allowin=1: the new instruction replaces the old, and ms_first is re-set. There is no gap or duplication.
- Stall of N cycles with ws_allowin=0: outputs are stable for all N cycles, including ms_rf_wdata for loads; the value comes from rdata_hold from cycle 2 onward.
- Reset asserted mid-stall: the instruction is dropped, and ms_valid=0 on the next cycle.
- Stores: es_rf_we=0 and es_res_from_mem=0, so the stage passes them through with ms_rf_we=0.

Optional Feature:
- Macro: MEM_SUBWORD_LOAD_EN.
- When defined:
  - Adds input es_ld_type [2:0], with encodings 0=word, 1=byte signed, 2=byte unsigned, 3=half signed, 4=half unsigned.
  - Captures es_ld_type and alu_result[1:0] at accept.
  - The load path selects the byte at offset addr[1:0], or the half at addr[1], then sign- or zero-extends it to DATA_W.
  - Selection applies equally to live data and rdata_hold.
  - Undefined encodings behave as word.
- When undefined: there is no es_ld_type port, and loads are always full word.

Test Plan:
- Reset → ms_valid=0, ms_allowin=1, ms_rf_we=0, ms_rf_wdata=0.
- ALU op, pc=0x1c000004, waddr=5, result=0x12345678, ws_allowin=1 → next cycle: ms_to_ws_valid=1, ms_rf_wdata=0x12345678, ms_rf_we=1, waddr=5; cycle after with no new input: ms_valid=0.
- Load, result=0x100; rdata=0xDEADBEEF in first cycle, ws_allowin=0 for 3 cycles, and rdata changed to 0x0 from cycle 2 → ms_rf_wdata=0xDEADBEEF for all 4 cycles; ms_allowin=0 while stalled.
- Four back-to-back ALU ops with ws_allowin=1 → one per cycle, in order, no bubble; ms_allowin held at 1.
- resetn low while a stalled load is held → ms_valid=0 and ms_res_from_mem=0 the next cycle.
- MEM_SUBWORD_LOAD_EN: rdata=0x80FF7F01, addr[1:0]=2, type=1 → 0xFFFFFFFF; type=3 with addr[1]=1 → 0xFFFF80FF; type=4 with addr[1]=0 → 0x00007F01.
